// File: rtl/dmem_pkg.sv
// Shared encodings for the MEM-stage data memory controller: access widths,
// fault codes and controller FSM states.
package dmem_pkg;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;

  localparam logic [1:0] F_NONE     = 2'b00;
  localparam logic [1:0] F_MISALIGN = 2'b01;
  localparam logic [1:0] F_RANGE    = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Width codes 1x both mean word.
  function automatic logic [2:0] access_size(input logic [1:0] width);
    if (width[1])      return 3'd4;
    else if (width[0]) return 3'd2;
    else               return 3'd1;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-organised storage array: synchronous byte-enabled write, registered read.
// Contents are deliberately not reset.
module dmem_bank #(
  parameter int unsigned WORDS = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  input  logic          re,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Handshaked big-endian data memory for the pipeline MEM stage, with wait
// states, alignment/range checking and a sticky first-fault record.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_width,
  input  logic        req_sign,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [1:0]  fault_code,
  output logic [31:0] fault_addr,
  output logic        fault_sticky,
  input  logic        fault_clr
);

  localparam int unsigned WORDS    = DEPTH_BYTES / 4;
  localparam int unsigned WAW      = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [2:0]  CNT_INIT = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q, we_d, sign_q, sign_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [1:0]  width_q, width_d;
  logic        ld_ok_q, ld_ok_d, ld_sign_q, ld_sign_d;
  logic [1:0]  ld_lane_q, ld_lane_d, ld_width_q, ld_width_d;
  logic        resp_fault_q, resp_fault_d;
  logic        sticky_q, sticky_d;
  logic [1:0]  code_q, code_d;
  logic [31:0] faddr_q, faddr_d;

  logic        accept, commit;
  logic        cur_we, cur_sign, cur_fault;
  logic [31:0] cur_addr, cur_wdata, cur_off;
  logic [1:0]  cur_width, cur_code;
  logic [32:0] end_off;
  logic [3:0]  bank_be;
  logic [31:0] bank_wdata, bank_rdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign accept = req_valid && (state_q != WAIT);

  // With zero wait states the access commits on the accept edge itself, so the
  // live request is used; otherwise the latched copy is used from WAIT.
  always_comb begin
    cur_we    = req_we;
    cur_addr  = req_addr;
    cur_wdata = req_wdata;
    cur_width = req_width;
    cur_sign  = req_sign;
    commit    = accept && (WAIT_STATES == 0);
    if (state_q == WAIT) begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_width = width_q;
      cur_sign  = sign_q;
      commit    = (cnt_q == 3'd0);
    end
  end

  always_comb begin
    cur_off = cur_addr - BASE_ADDR;
    end_off = {1'b0, cur_off} + {30'd0, access_size(cur_width)};
    if ((cur_width[1] && cur_addr[1:0] != 2'b00) || (cur_width == W_HALF && cur_addr[0]))
      cur_code = F_MISALIGN;
    else if (end_off > 33'(DEPTH_BYTES))
      cur_code = F_RANGE;
    else
      cur_code = F_NONE;
    cur_fault = (cur_code != F_NONE);

    // Big-endian: byte offset 0 lives in bits [31:24].
    case (cur_width)
      W_BYTE: begin
        bank_be    = 4'b1000 >> cur_addr[1:0];
        bank_wdata = {4{cur_wdata[7:0]}};
      end
      W_HALF: begin
        bank_be    = cur_addr[1] ? 4'b0011 : 4'b1100;
        bank_wdata = {2{cur_wdata[15:0]}};
      end
      default: begin
        bank_be    = 4'b1111;
        bank_wdata = cur_wdata;
      end
    endcase
  end

  dmem_bank #(
    .WORDS (WORDS),
    .AW    (WAW)
  ) u_bank (
    .clk   (clk),
    .addr  (cur_off[WAW+1:2]),
    .we    (commit && cur_we && !cur_fault),
    .be    (bank_be),
    .wdata (bank_wdata),
    .re    (commit && !cur_we && !cur_fault),
    .rdata (bank_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    width_d = width_q;
    sign_d  = sign_q;
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (accept) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          width_d = req_width;
          sign_d  = req_sign;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ld_ok_d      = ld_ok_q;
    ld_lane_d    = ld_lane_q;
    ld_width_d   = ld_width_q;
    ld_sign_d    = ld_sign_q;
    resp_fault_d = commit && cur_fault;
    sticky_d     = sticky_q;
    code_d       = code_q;
    faddr_d      = faddr_q;
    if (commit) begin
      ld_ok_d    = !cur_we && !cur_fault;
      ld_lane_d  = cur_addr[1:0];
      ld_width_d = cur_width;
      ld_sign_d  = cur_sign;
    end
    // A fault committing alongside a clear wins, so it is never lost.
    if (commit && cur_fault && (!sticky_q || fault_clr)) begin
      sticky_d = 1'b1;
      code_d   = cur_code;
      faddr_d  = cur_addr;
    end else if (fault_clr) begin
      sticky_d = 1'b0;
      code_d   = F_NONE;
      faddr_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      width_q      <= '0;
      sign_q       <= 1'b0;
      ld_ok_q      <= 1'b0;
      ld_lane_q    <= '0;
      ld_width_q   <= '0;
      ld_sign_q    <= 1'b0;
      resp_fault_q <= 1'b0;
      sticky_q     <= 1'b0;
      code_q       <= F_NONE;
      faddr_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      width_q      <= width_d;
      sign_q       <= sign_d;
      ld_ok_q      <= ld_ok_d;
      ld_lane_q    <= ld_lane_d;
      ld_width_q   <= ld_width_d;
      ld_sign_q    <= ld_sign_d;
      resp_fault_q <= resp_fault_d;
      sticky_q     <= sticky_d;
      code_q       <= code_d;
      faddr_q      <= faddr_d;
    end
  end

  always_comb begin
    case (ld_lane_q)
      2'd0:    ld_byte = bank_rdata[31:24];
      2'd1:    ld_byte = bank_rdata[23:16];
      2'd2:    ld_byte = bank_rdata[15:8];
      default: ld_byte = bank_rdata[7:0];
    endcase
    ld_half = ld_lane_q[1] ? bank_rdata[15:0] : bank_rdata[31:16];
    if (!ld_ok_q)          resp_rdata = '0;
    else if (ld_width_q[1]) resp_rdata = bank_rdata;
    else if (ld_width_q[0]) resp_rdata = {{16{ld_half[15] & ld_sign_q}}, ld_half};
    else                    resp_rdata = {{24{ld_byte[7] & ld_sign_q}}, ld_byte};
  end

  assign req_ready    = (state_q != WAIT) && !rst;
  assign resp_valid   = (state_q == RESP);
  assign resp_fault   = resp_fault_q;
  assign fault_code   = code_q;
  assign fault_addr   = faddr_q;
  assign fault_sticky = sticky_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: three instances with 1, 0 and 3 wait states,
// a vector table for the load/store datapath and hand sequences for corner cases.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rq_valid [3];
  logic        rq_we    [3];
  logic        rq_sign  [3];
  logic        clr      [3];
  logic [31:0] rq_addr  [3];
  logic [31:0] rq_wdata [3];
  logic [1:0]  rq_width [3];
  logic        rs_ready [3];
  logic        rs_valid [3];
  logic        rs_fault [3];
  logic        f_sticky [3];
  logic [31:0] rs_rdata [3];
  logic [31:0] f_addr   [3];
  logic [1:0]  f_code   [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.BASE_ADDR(32'h1001_0000), .DEPTH_BYTES(1024), .WAIT_STATES(1)) dut_a (
    .clk(clk), .rst(rst), .req_valid(rq_valid[0]), .req_ready(rs_ready[0]), .req_we(rq_we[0]),
    .req_addr(rq_addr[0]), .req_wdata(rq_wdata[0]), .req_width(rq_width[0]), .req_sign(rq_sign[0]),
    .resp_valid(rs_valid[0]), .resp_rdata(rs_rdata[0]), .resp_fault(rs_fault[0]),
    .fault_code(f_code[0]), .fault_addr(f_addr[0]), .fault_sticky(f_sticky[0]), .fault_clr(clr[0]));

  data_mem_ctrl #(.BASE_ADDR(32'h1001_0000), .DEPTH_BYTES(1024), .WAIT_STATES(0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(rq_valid[1]), .req_ready(rs_ready[1]), .req_we(rq_we[1]),
    .req_addr(rq_addr[1]), .req_wdata(rq_wdata[1]), .req_width(rq_width[1]), .req_sign(rq_sign[1]),
    .resp_valid(rs_valid[1]), .resp_rdata(rs_rdata[1]), .resp_fault(rs_fault[1]),
    .fault_code(f_code[1]), .fault_addr(f_addr[1]), .fault_sticky(f_sticky[1]), .fault_clr(clr[1]));

  data_mem_ctrl #(.BASE_ADDR(32'h1001_0000), .DEPTH_BYTES(1024), .WAIT_STATES(3)) dut_c (
    .clk(clk), .rst(rst), .req_valid(rq_valid[2]), .req_ready(rs_ready[2]), .req_we(rq_we[2]),
    .req_addr(rq_addr[2]), .req_wdata(rq_wdata[2]), .req_width(rq_width[2]), .req_sign(rq_sign[2]),
    .resp_valid(rs_valid[2]), .resp_rdata(rs_rdata[2]), .resp_fault(rs_fault[2]),
    .fault_code(f_code[2]), .fault_addr(f_addr[2]), .fault_sticky(f_sticky[2]), .fault_clr(clr[2]));

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  width;
    logic        sign;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out", nm);
  endtask

  // lat counts clock edges from the accept edge to the edge that samples resp_valid.
  task automatic txn(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [1:0] width, input logic sign,
                     output logic [31:0] rdata, output logic fault, output int lat, output int rdy_low);
    int n;
    rdata = '0; fault = 1'b0; lat = 0; rdy_low = 0;
    rq_valid[d] = 1'b1; rq_we[d] = we; rq_addr[d] = addr; rq_wdata[d] = wdata;
    rq_width[d] = width; rq_sign[d] = sign;
    n = 0;
    while (!rs_ready[d] && n < 20) begin @(posedge clk); #1; n++; end
    if (!rs_ready[d]) begin
      timeout("txn ready");
      rq_valid[d] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    rq_valid[d] = 1'b0;
    n = 0;
    while (!rs_valid[d] && n < 20) begin
      if (!rs_ready[d]) rdy_low++;
      @(posedge clk); #1; n++;
    end
    if (!rs_valid[d]) begin
      timeout("txn resp_valid");
      return;
    end
    lat = n + 1;
    rdata = rs_rdata[d];
    fault = rs_fault[d];
    @(posedge clk); #1;
    chk("resp_valid pulse width", {31'd0, rs_valid[d]}, 32'd0);
  endtask

  vec_t        vecs [16];
  logic [31:0] rd;
  logic        flt;
  int          lat, rl;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 32'h1001_0010, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b0, 32'h1001_0010, 32'h0,         2'b00, 1'b1, 32'hFFFF_FFDE};
    vecs[2]  = '{1'b0, 32'h1001_0012, 32'h0,         2'b01, 1'b0, 32'h0000_BEEF};
    vecs[3]  = '{1'b0, 32'h1001_0011, 32'h0,         2'b00, 1'b0, 32'h0000_00AD};
    vecs[4]  = '{1'b0, 32'h1001_0013, 32'h0,         2'b00, 1'b1, 32'hFFFF_FFEF};
    vecs[5]  = '{1'b0, 32'h1001_0012, 32'h0,         2'b01, 1'b1, 32'hFFFF_BEEF};
    vecs[6]  = '{1'b0, 32'h1001_0010, 32'h0,         2'b01, 1'b0, 32'h0000_DEAD};
    vecs[7]  = '{1'b1, 32'h1001_0011, 32'h1234_5677, 2'b00, 1'b0, 32'h0000_0000};
    vecs[8]  = '{1'b0, 32'h1001_0010, 32'h0,         2'b10, 1'b0, 32'hDE77_BEEF};
    vecs[9]  = '{1'b1, 32'h1001_0012, 32'hAAAA_8001, 2'b01, 1'b0, 32'h0000_0000};
    vecs[10] = '{1'b0, 32'h1001_0010, 32'h0,         2'b10, 1'b0, 32'hDE77_8001};
    vecs[11] = '{1'b1, 32'h1001_03FC, 32'h0102_0304, 2'b10, 1'b0, 32'h0000_0000};
    vecs[12] = '{1'b0, 32'h1001_03FF, 32'h0,         2'b00, 1'b0, 32'h0000_0004};
    vecs[13] = '{1'b0, 32'h1001_03FE, 32'h0,         2'b01, 1'b1, 32'h0000_0304};
    vecs[14] = '{1'b0, 32'h1001_03FC, 32'h0,         2'b00, 1'b1, 32'h0000_0001};
    vecs[15] = '{1'b0, 32'h1001_03FC, 32'h0,         2'b11, 1'b0, 32'h0102_0304};

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rq_valid[i] = 1'b0; rq_we[i] = 1'b0; rq_sign[i] = 1'b0; clr[i] = 1'b0;
      rq_addr[i] = '0; rq_wdata[i] = '0; rq_width[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready", {31'd0, rs_ready[0]}, 32'd0);
    chk("reset resp_valid", {31'd0, rs_valid[0]}, 32'd0);
    chk("reset resp_rdata", rs_rdata[0], 32'd0);
    chk("reset fault_sticky", {31'd0, f_sticky[0]}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post-reset req_ready", {31'd0, rs_ready[0]}, 32'd1);

    // Datapath table on the one-wait-state instance.
    for (int i = 0; i < 16; i++) begin
      txn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].width, vecs[i].sign, rd, flt, lat, rl);
      chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d fault", i), {31'd0, flt}, 32'd0);
      chk($sformatf("vec%0d latency", i), lat, 32'd2);
      chk($sformatf("vec%0d ready low cycles", i), rl, 32'd1);
    end

    // Fault record: first fault sticks, later faults leave it alone.
    chk("sticky before faults", {31'd0, f_sticky[0]}, 32'd0);
    txn(0, 1'b0, 32'h1001_0011, 32'h0, 2'b01, 1'b0, rd, flt, lat, rl);
    chk("misalign half rdata", rd, 32'd0);
    chk("misalign half fault", {31'd0, flt}, 32'd1);
    chk("misalign code", {30'd0, f_code[0]}, 32'd1);
    chk("misalign addr", f_addr[0], 32'h1001_0011);
    chk("misalign sticky", {31'd0, f_sticky[0]}, 32'd1);
    txn(0, 1'b0, 32'h1000_FFFC, 32'h0, 2'b10, 1'b0, rd, flt, lat, rl);
    chk("below-base fault", {31'd0, flt}, 32'd1);
    chk("record kept code", {30'd0, f_code[0]}, 32'd1);
    chk("record kept addr", f_addr[0], 32'h1001_0011);
    txn(0, 1'b0, 32'h1001_0400, 32'h0, 2'b00, 1'b0, rd, flt, lat, rl);
    chk("past-end byte fault", {31'd0, flt}, 32'd1);
    txn(0, 1'b0, 32'h1001_03FE, 32'h0, 2'b10, 1'b0, rd, flt, lat, rl);
    chk("misalign word rdata", rd, 32'd0);

    clr[0] = 1'b1;
    @(posedge clk); #1;
    clr[0] = 1'b0;
    chk("clear sticky", {31'd0, f_sticky[0]}, 32'd0);
    chk("clear code", {30'd0, f_code[0]}, 32'd0);
    chk("clear addr", f_addr[0], 32'd0);

    // Only the aligned, in-range store may change memory.
    txn(0, 1'b1, 32'h1001_03FE, 32'hBADB_AD00, 2'b10, 1'b0, rd, flt, lat, rl);
    chk("misalign store fault", {31'd0, flt}, 32'd1);
    chk("misalign store code", {30'd0, f_code[0]}, 32'd1);
    chk("misalign store addr", f_addr[0], 32'h1001_03FE);
    txn(0, 1'b1, 32'h1000_FFFC, 32'hCAFE_F00D, 2'b10, 1'b0, rd, flt, lat, rl);
    chk("range store fault", {31'd0, flt}, 32'd1);
    txn(0, 1'b0, 32'h1001_03FC, 32'h0, 2'b10, 1'b0, rd, flt, lat, rl);
    chk("after faulted stores", rd, 32'h0102_0304);
    txn(0, 1'b1, 32'h1001_03FC, 32'h5566_7788, 2'b10, 1'b0, rd, flt, lat, rl);
    chk("good store fault", {31'd0, flt}, 32'd0);
    txn(0, 1'b0, 32'h1001_03FC, 32'h0, 2'b10, 1'b0, rd, flt, lat, rl);
    chk("after good store", rd, 32'h5566_7788);

    // Clear on the same edge as a range fault commit.
    rq_valid[0] = 1'b1; rq_we[0] = 1'b0; rq_addr[0] = 32'h1000_FFFC; rq_width[0] = 2'b10;
    @(posedge clk); #1;
    rq_valid[0] = 1'b0;
    clr[0] = 1'b1;
    @(posedge clk); #1;
    clr[0] = 1'b0;
    chk("clr+fault resp_fault", {31'd0, rs_fault[0]}, 32'd1);
    chk("clr+fault sticky", {31'd0, f_sticky[0]}, 32'd1);
    chk("clr+fault code", {30'd0, f_code[0]}, 32'd2);
    chk("clr+fault addr", f_addr[0], 32'h1000_FFFC);
    @(posedge clk); #1;

    // Reset in the middle of a store's wait state.
    txn(0, 1'b1, 32'h1001_0020, 32'h1111_1111, 2'b10, 1'b0, rd, flt, lat, rl);
    txn(0, 1'b0, 32'h1001_03FC, 32'h0, 2'b10, 1'b0, rd, flt, lat, rl);
    chk("pre-reset load", rd, 32'h5566_7788);
    rq_valid[0] = 1'b1; rq_we[0] = 1'b1; rq_addr[0] = 32'h1001_0020;
    rq_wdata[0] = 32'h9999_9999; rq_width[0] = 2'b10;
    @(posedge clk); #1;
    rq_valid[0] = 1'b0;
    chk("in WAIT ready", {31'd0, rs_ready[0]}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rst req_ready", {31'd0, rs_ready[0]}, 32'd0);
    chk("rst resp_valid", {31'd0, rs_valid[0]}, 32'd0);
    chk("rst resp_rdata", rs_rdata[0], 32'd0);
    chk("rst resp_fault", {31'd0, rs_fault[0]}, 32'd0);
    chk("rst fault_code", {30'd0, f_code[0]}, 32'd0);
    chk("rst fault_addr", f_addr[0], 32'd0);
    chk("rst fault_sticky", {31'd0, f_sticky[0]}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    txn(0, 1'b0, 32'h1001_0020, 32'h0, 2'b10, 1'b0, rd, flt, lat, rl);
    chk("dropped store not written", rd, 32'h1111_1111);

    // Zero wait states: store then load of the same word on consecutive accepts.
    rq_valid[1] = 1'b1; rq_we[1] = 1'b1; rq_addr[1] = 32'h1001_0040;
    rq_wdata[1] = 32'hA5A5_5A5A; rq_width[1] = 2'b10;
    @(posedge clk); #1;
    chk("ws0 store resp_valid", {31'd0, rs_valid[1]}, 32'd1);
    chk("ws0 store rdata", rs_rdata[1], 32'd0);
    chk("ws0 ready in RESP", {31'd0, rs_ready[1]}, 32'd1);
    rq_we[1] = 1'b0;
    @(posedge clk); #1;
    rq_valid[1] = 1'b0;
    chk("ws0 load resp_valid", {31'd0, rs_valid[1]}, 32'd1);
    chk("ws0 load rdata", rs_rdata[1], 32'hA5A5_5A5A);
    @(posedge clk); #1;
    chk("ws0 idle resp_valid", {31'd0, rs_valid[1]}, 32'd0);
    chk("ws0 rdata holds", rs_rdata[1], 32'hA5A5_5A5A);
    txn(1, 1'b0, 32'h1001_0042, 32'h0, 2'b01, 1'b0, rd, flt, lat, rl);
    chk("ws0 half rdata", rd, 32'h0000_5A5A);
    chk("ws0 latency", lat, 32'd1);
    chk("ws0 ready low cycles", rl, 32'd0);
    txn(1, 1'b0, 32'h1001_0041, 32'h0, 2'b01, 1'b0, rd, flt, lat, rl);
    chk("ws0 misalign fault", {31'd0, flt}, 32'd1);
    chk("ws0 misalign code", {30'd0, f_code[1]}, 32'd1);

    // Three wait states: longer latency and ready held low throughout WAIT.
    txn(2, 1'b1, 32'h1001_0000, 32'h0F0F_0F0F, 2'b10, 1'b0, rd, flt, lat, rl);
    chk("ws3 store latency", lat, 32'd4);
    chk("ws3 ready low cycles", rl, 32'd3);
    txn(2, 1'b0, 32'h1001_0001, 32'h0, 2'b00, 1'b1, rd, flt, lat, rl);
    chk("ws3 load rdata", rd, 32'h0000_000F);
    chk("ws3 load latency", lat, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
